tff_toggle_monitor: RTL and testbench

//  Downstream consumer of the T flip-flop. Samples Q/Qbar and emits a 1-cycle

---
 rtl/tff_toggle_monitor.sv | 91 +++++++++
 tb/tb_tff_toggle_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tff_toggle_monitor.sv
// Watches a T flip-flop's Q/Qbar: one registered pulse per Q toggle, counts toggles up to a target, flags Q==Qbar.
// toggle_pulse lags Q by two edges; count lags by the same two edges; no backpressure, every toggle is seen.
module tff_toggle_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             q_in,
  input  logic             qbar_in,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] target,
  input  logic             ack,
  output logic             toggle_pulse,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             pair_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic             q_s1;
  logic             q_s2;
  logic [CNT_W-1:0] tgt_r;
  logic             tgl_det;
  logic [CNT_W-1:0] count_inc;
  logic             pair_eq;
  logic             start_acc;

  assign tgl_det   = q_s1 ^ q_s2;
  assign count_inc = count + 1'b1;
  assign pair_eq   = (q_in == qbar_in);
  assign start_acc = (state == IDLE) && start;

  // Both flags decode straight from the state register, so no input reaches them combinationally.
  assign busy = (state == COUNT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      q_s1         <= 1'b0;
      q_s2         <= 1'b0;
      tgt_r        <= '0;
      count        <= '0;
      toggle_pulse <= 1'b0;
      pair_err     <= 1'b0;
    end else begin
      q_s1         <= q_in;
      q_s2         <= q_s1;
      toggle_pulse <= tgl_det;

      // A fresh measurement discards history but still records a bad pair seen on the same edge.
      if (start_acc)
        pair_err <= pair_eq;
      else if (pair_eq)
        pair_err <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            tgt_r <= target;
            count <= '0;
            state <= (target == '0) ? DONE : COUNT;
          end
        end
        COUNT: begin
          if (stop) begin
            state <= IDLE;
          end else if (tgl_det) begin
            count <= count_inc;
            if (count_inc == tgt_r)
              state <= DONE;
          end
        end
        DONE: begin
          if (stop || ack)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tff_toggle_monitor.sv
// Directed, table-driven bench for tff_toggle_monitor plus hand sequences for multi-cycle corners.
module tb_tff_toggle_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       q_in;
  logic       qbar_in;
  logic       start;
  logic       stop;
  logic [7:0] target;
  logic       ack;
  logic       toggle_pulse;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       pair_err;

  int errors = 0;
  int checks = 0;

  tff_toggle_monitor #(.CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .q_in         (q_in),
    .qbar_in      (qbar_in),
    .start        (start),
    .stop         (stop),
    .target       (target),
    .ack          (ack),
    .toggle_pulse (toggle_pulse),
    .count        (count),
    .busy         (busy),
    .done         (done),
    .pair_err     (pair_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       q;
    logic       qb;
    logic       st;
    logic       sp;
    logic [7:0] tgt;
    logic       ak;
    logic       tp;
    logic [7:0] cnt;
    logic       bsy;
    logic       dn;
    logic       pe;
  } vec_t;

  localparam int NV = 36;
  vec_t vt [NV];

  function automatic vec_t mk(input logic rst, q, qb, st, sp, input logic [7:0] tgt,
                              input logic ak, tp, input logic [7:0] cnt,
                              input logic bsy, dn, pe);
    vec_t v;
    v.rst = rst; v.q = q; v.qb = qb; v.st = st; v.sp = sp; v.tgt = tgt; v.ak = ak;
    v.tp = tp; v.cnt = cnt; v.bsy = bsy; v.dn = dn; v.pe = pe;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic flip_q();
    q_in    = ~q_in;
    qbar_in = ~q_in;
  endtask

  initial begin
    int n;
    logic [11:0] act, exp;

    //            rst q qb st sp tgt ak | tp cnt bsy dn pe
    vt[0]  = mk(0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    vt[2]  = mk(1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    vt[3]  = mk(1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    vt[4]  = mk(1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    vt[5]  = mk(1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
    vt[6]  = mk(1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    vt[7]  = mk(1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    vt[8]  = mk(1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
    vt[9]  = mk(1, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0);
    vt[10] = mk(1, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0);
    vt[11] = mk(1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    // target=4 count run
    vt[12] = mk(1, 0, 1, 1, 0, 4, 0,   0, 0, 1, 0, 0);
    vt[13] = mk(1, 1, 0, 0, 0, 4, 0,   0, 0, 1, 0, 0);
    vt[14] = mk(1, 0, 1, 0, 0, 4, 0,   1, 1, 1, 0, 0);
    vt[15] = mk(1, 1, 0, 0, 0, 4, 0,   1, 2, 1, 0, 0);
    vt[16] = mk(1, 0, 1, 0, 0, 4, 0,   1, 3, 1, 0, 0);
    vt[17] = mk(1, 1, 0, 0, 0, 4, 0,   1, 4, 0, 1, 0);
    vt[18] = mk(1, 0, 1, 0, 0, 4, 0,   1, 4, 0, 1, 0);
    vt[19] = mk(1, 0, 1, 0, 0, 4, 0,   1, 4, 0, 1, 0);
    vt[20] = mk(1, 0, 1, 0, 0, 4, 1,   0, 4, 0, 0, 0);
    // start coinciding with a toggle, start ignored in COUNT, stop at count 3 of 5
    vt[21] = mk(1, 1, 0, 0, 0, 5, 0,   0, 4, 0, 0, 0);
    vt[22] = mk(1, 1, 0, 1, 0, 5, 0,   1, 0, 1, 0, 0);
    vt[23] = mk(1, 1, 0, 1, 0, 1, 0,   0, 0, 1, 0, 0);
    vt[24] = mk(1, 0, 1, 0, 0, 1, 0,   0, 0, 1, 0, 0);
    vt[25] = mk(1, 1, 0, 0, 0, 1, 0,   1, 1, 1, 0, 0);
    vt[26] = mk(1, 0, 1, 0, 0, 1, 0,   1, 2, 1, 0, 0);
    vt[27] = mk(1, 1, 0, 0, 0, 1, 0,   1, 3, 1, 0, 0);
    vt[28] = mk(1, 1, 0, 0, 1, 1, 0,   1, 3, 0, 0, 0);
    vt[29] = mk(1, 1, 0, 0, 0, 1, 0,   0, 3, 0, 0, 0);
    // pair error, cleared by start with target=0 (straight to DONE)
    vt[30] = mk(1, 1, 1, 0, 0, 0, 0,   0, 3, 0, 0, 1);
    vt[31] = mk(1, 1, 0, 0, 0, 0, 0,   0, 3, 0, 0, 1);
    vt[32] = mk(1, 1, 0, 0, 0, 0, 0,   0, 3, 0, 0, 1);
    vt[33] = mk(1, 1, 0, 1, 0, 0, 0,   0, 0, 0, 1, 0);
    vt[34] = mk(1, 1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
    vt[35] = mk(1, 1, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0);

    reset = 1'b0; q_in = 1'b0; qbar_in = 1'b1; start = 1'b0; stop = 1'b0;
    target = '0; ack = 1'b0;

    for (int i = 0; i < NV; i++) begin
      reset = vt[i].rst; q_in = vt[i].q; qbar_in = vt[i].qb; start = vt[i].st;
      stop = vt[i].sp; target = vt[i].tgt; ack = vt[i].ak;
      tick();
      act = {toggle_pulse, count, busy, done, pair_err};
      exp = {vt[i].tp, vt[i].cnt, vt[i].bsy, vt[i].dn, vt[i].pe};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL row%0d: got tp=%b cnt=%0d busy=%b done=%b perr=%b, expected tp=%b cnt=%0d busy=%b done=%b perr=%b",
                 i, toggle_pulse, count, busy, done, pair_err,
                 vt[i].tp, vt[i].cnt, vt[i].bsy, vt[i].dn, vt[i].pe);
      end
    end
    start = 1'b0; stop = 1'b0; ack = 1'b0;

    // Reset in the middle of a target=8 measurement
    target = 8; start = 1'b1; tick(); start = 1'b0;
    chk("midrst_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin flip_q(); tick(); end
    tick();
    chk("midrst_cnt3", count, 3);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      flip_q(); tick();
      chk("midrst_in_cnt", count, 0);
      chk("midrst_in_busy", busy, 0);
      chk("midrst_in_tp", toggle_pulse, 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      flip_q(); tick();
      chk("midrst_after_done", done, 0);
      chk("midrst_after_cnt", count, 0);
    end

    // DONE: start ignored until ack, stop returns to IDLE
    tick(); tick();
    target = 1; start = 1'b1; tick(); start = 1'b0;
    chk("t1_busy", busy, 1);
    flip_q(); tick(); tick();
    chk("t1_done", done, 1);
    chk("t1_cnt", count, 1);
    target = 3; start = 1'b1; tick(); start = 1'b0;
    chk("done_start_ign_done", done, 1);
    chk("done_start_ign_busy", busy, 0);
    chk("done_start_ign_cnt", count, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("done_stop_done", done, 0);
    chk("done_stop_busy", busy, 0);
    chk("done_stop_cnt", count, 1);

    // Full target=8 run with a bounded wait for done
    tick(); tick();
    target = 8; start = 1'b1; tick(); start = 1'b0; target = 0;
    n = 0;
    while (!done && n < 30) begin
      flip_q(); tick(); n++;
    end
    chk("t8_done", done, 1);
    chk("t8_cycles", n, 9);
    chk("t8_cnt", count, 8);
    for (int i = 0; i < 3; i++) begin flip_q(); tick(); end
    chk("t8_cnt_hold", count, 8);
    chk("t8_done_hold", done, 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t8_ack", done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
